// File: rtl/rf_dump_loader.sv
// rtl/rf_dump_loader.sv - streams the 32x32 register file out (DUMP) or in (LOAD) over valid/ready.
// Optional XOR checksum of streamed words when RF_DUMP_CHECKSUM_EN is defined.
module rf_dump_loader #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_dump,
    input  logic          start_load,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rf_a1,
    input  logic [DW-1:0] rf_rd1,
    output logic          rf_we3,
    output logic [AW-1:0] rf_a3,
    output logic [DW-1:0] rf_wd3,
    output logic [DW-1:0] dout_data,
    output logic [AW-1:0] dout_idx,
    output logic          dout_valid,
    input  logic          dout_ready,
    input  logic [DW-1:0] din_data,
    input  logic          din_valid,
    output logic          din_ready
`ifdef RF_DUMP_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DUMP,
        S_LOAD,
        S_FIN
    } state_t;

    localparam logic [AW:0] LAST = (AW + 1)'(NREGS - 1);

    state_t      state;
    state_t      state_next;
    logic [AW:0] idx;
    logic        dump_tail;   // last register already captured into the output register
    logic        dout_load;
    logic        dout_hs;
    logic        din_hs;

    assign dout_hs   = (state == S_DUMP) && dout_valid && dout_ready;
    assign din_hs    = din_valid && din_ready;
    assign dout_load = (state == S_DUMP) && !dump_tail && (!dout_valid || dout_ready);

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        din_ready  = 1'b0;
        rf_a1      = '0;
        case (state)
            S_IDLE: begin
                if (start_dump) begin
                    state_next = S_DUMP;
                end else if (start_load) begin
                    state_next = S_LOAD;
                end
            end
            S_DUMP: begin
                busy  = 1'b1;
                rf_a1 = idx[AW-1:0];
                if (dout_hs && dump_tail) begin
                    state_next = S_FIN;
                end
            end
            S_LOAD: begin
                busy      = 1'b1;
                din_ready = 1'b1;
                if (din_valid && idx == LAST) begin
                    state_next = S_FIN;
                end
            end
            S_FIN: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            dump_tail  <= 1'b0;
            rf_we3     <= 1'b0;
            rf_a3      <= '0;
            rf_wd3     <= '0;
            dout_data  <= '0;
            dout_idx   <= '0;
            dout_valid <= 1'b0;
        end else begin
            state  <= state_next;
            rf_we3 <= 1'b0;
            case (state)
                S_IDLE: begin
                    dump_tail <= 1'b0;
                    if (start_dump) begin
                        idx <= '0;
                    end else if (start_load) begin
                        // x0 is hard-wired to zero, so loading begins at x1
                        idx <= (AW + 1)'(1);
                    end
                end
                S_DUMP: begin
                    if (dout_load) begin
                        dout_data  <= rf_rd1;
                        dout_idx   <= idx[AW-1:0];
                        dout_valid <= 1'b1;
                        idx        <= idx + 1'b1;
                        if (idx == LAST) begin
                            dump_tail <= 1'b1;
                        end
                    end else if (dout_hs) begin
                        dout_valid <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (din_hs) begin
                        rf_we3 <= 1'b1;
                        rf_a3  <= idx[AW-1:0];
                        rf_wd3 <= din_data;
                        idx    <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RF_DUMP_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (state == S_IDLE && (start_dump || start_load)) begin
            checksum <= '0;
        end else if (dout_hs) begin
            checksum <= checksum ^ dout_data;
        end else if (din_hs) begin
            checksum <= checksum ^ din_data;
        end
    end
`endif

endmodule

// File: tb/tb_rf_dump_loader.sv
// tb/tb_rf_dump_loader.sv - randomized directed bench for rf_dump_loader with RF and stream model.
module tb_rf_dump_loader;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_dump = 1'b0;
    logic          start_load = 1'b0;
    logic          busy, done;
    logic [AW-1:0] rf_a1;
    logic [DW-1:0] rf_rd1;
    logic          rf_we3;
    logic [AW-1:0] rf_a3;
    logic [DW-1:0] rf_wd3;
    logic [DW-1:0] dout_data;
    logic [AW-1:0] dout_idx;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic [DW-1:0] din_data = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
`ifdef RF_DUMP_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] rf_mem [NREGS];
    logic [DW-1:0] exp_rf [NREGS];
    logic          preset = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preset) begin
            for (int i = 0; i < NREGS; i++) rf_mem[i] <= (i == 0) ? '0 : 32'h1000_0000 + i;
        end else if (rf_we3 && rf_a3 != 0) begin
            rf_mem[rf_a3] <= rf_wd3;
        end
    end
    assign rf_rd1 = (rf_a1 == 0) ? '0 : rf_mem[rf_a1];

    rf_dump_loader #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start_dump(start_dump), .start_load(start_load),
        .busy(busy), .done(done), .rf_a1(rf_a1), .rf_rd1(rf_rd1),
        .rf_we3(rf_we3), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
        .dout_data(dout_data), .dout_idx(dout_idx), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready)
`ifdef RF_DUMP_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_we3"}, 32'(rf_we3), 0);
        check({tag, "_dvalid"}, 32'(dout_valid), 0);
        check({tag, "_dinrdy"}, 32'(din_ready), 0);
        check({tag, "_a1"}, 32'(rf_a1), 0);
        check({tag, "_a3"}, 32'(rf_a3), 0);
        check({tag, "_didx"}, 32'(dout_idx), 0);
        check({tag, "_wd3"}, rf_wd3, 0);
        check({tag, "_ddata"}, dout_data, 0);
    endtask

    task automatic check_rf(input string tag);
        int bad = 0;
        for (int i = 0; i < NREGS; i++) if (rf_mem[i] !== exp_rf[i]) bad++;
        check({tag, "_rf_contents"}, 32'(bad), 0);
        check({tag, "_x0_zero"}, rf_mem[0], 0);
    endtask

    // mode 0: ready held high, 1: ready pattern 1,0,0 repeating, 2: random ready
    task automatic run_dump(input string tag, input int mode, input bit both);
        logic [DW-1:0] got_d[$];
        int            got_i[$];
        int            cyc = 0, first_cyc = -1, last_cyc = -1, done_cyc = -1;
        int            stab_err = 0, wr_err = 0;
        bit            stalled = 0;
        logic [DW-1:0] sd = '0;
        logic [AW-1:0] si = '0;
        logic [DW-1:0] xr = '0;
        @(posedge clk); #1;
        start_dump = 1'b1;
        start_load = both;
        dout_ready = (mode != 2) ? 1'b1 : 1'(($urandom_range(0, 1)));
        @(posedge clk); #1;
        start_dump = 1'b0;
        start_load = 1'b0;
        check({tag, "_busy"}, 32'(busy), 1);
        check({tag, "_not_load"}, 32'(din_ready), 0);
        while (cyc < 500 && done_cyc < 0) begin
            @(negedge clk);
            if (stalled && (dout_data !== sd || dout_idx !== si)) stab_err++;
            if (din_ready || rf_we3) wr_err++;
            if (done) done_cyc = cyc;
            if (dout_valid && dout_ready) begin
                got_d.push_back(dout_data);
                got_i.push_back(int'(dout_idx));
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            stalled = dout_valid && !dout_ready;
            sd = dout_data;
            si = dout_idx;
            @(posedge clk); #1;
            cyc++;
            if (mode == 0) dout_ready = 1'b1;
            else if (mode == 1) dout_ready = (cyc % 3 == 0);
            else dout_ready = 1'($urandom_range(0, 1));
            start_load = both && (cyc == 5);
        end
        start_load = 1'b0;
        dout_ready = 1'b0;
        check({tag, "_done_seen"}, 32'(done_cyc >= 0), 1);
        check({tag, "_word_count"}, 32'(got_d.size()), NREGS);
        for (int k = 0; k < got_d.size() && k < NREGS; k++) begin
            check($sformatf("%s_idx%0d", tag, k), got_i[k], k);
            check($sformatf("%s_data%0d", tag, k), got_d[k], exp_rf[k]);
            xr ^= exp_rf[k];
        end
        check({tag, "_stall_stable"}, 32'(stab_err), 0);
        check({tag, "_no_load_activity"}, 32'(wr_err), 0);
        check({tag, "_done_after_last"}, done_cyc, last_cyc + 1);
        if (mode == 0) begin
            check({tag, "_first_latency"}, first_cyc, 1);
            check({tag, "_contiguous"}, last_cyc - first_cyc, NREGS - 1);
        end
        check({tag, "_idle_busy"}, 32'(busy), 0);
`ifdef RF_DUMP_CHECKSUM_EN
        check({tag, "_checksum"}, checksum, xr);
`endif
    endtask

    task automatic run_load(input string tag, input int abort_at);
        int hs = 0, pulses = 0, cyc = 0, wr_err = 0, post_err = 0;
        bit done_seen = 0;
        logic [DW-1:0] xr = '0;
        @(posedge clk); #1;
        start_load = 1'b1;
        @(posedge clk); #1;
        start_load = 1'b0;
        check({tag, "_busy"}, 32'(busy), 1);
        check({tag, "_din_ready"}, 32'(din_ready), 1);
        din_valid = 1'($urandom_range(0, 2) != 0);
        din_data  = 32'hA5A5_0001;
        while (cyc < 1000 && !done_seen) begin
            @(negedge clk);
            if (rf_we3) begin
                pulses++;
                if (rf_a3 !== AW'(pulses) || rf_wd3 !== 32'hA5A5_0000 + pulses) wr_err++;
            end
            if (done) done_seen = 1;
            if (din_valid && din_ready) begin
                hs++;
                exp_rf[hs] = 32'hA5A5_0000 + hs;
                xr ^= exp_rf[hs];
            end
            @(posedge clk); #1;
            cyc++;
            if (abort_at != 0 && hs == abort_at) break;
            din_valid = (hs < NREGS - 1) && ($urandom_range(0, 2) != 0);
            din_data  = 32'hA5A5_0000 + hs + 1;
        end
        din_valid = 1'b0;
        check({tag, "_write_fields"}, 32'(wr_err), 0);
        if (abort_at != 0) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check_idle_outputs({tag, "_abort"});
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (rf_we3 || done || busy) post_err++;
            end
            check({tag, "_quiet_after_abort"}, 32'(post_err), 0);
            check({tag, "_hs_at_abort"}, hs, abort_at);
        end else begin
            check({tag, "_done_seen"}, 32'(done_seen), 1);
            check({tag, "_handshakes"}, hs, NREGS - 1);
            check({tag, "_we3_pulses"}, pulses, NREGS - 1);
`ifdef RF_DUMP_CHECKSUM_EN
            check({tag, "_checksum"}, checksum, xr);
`endif
            @(negedge clk);
            check({tag, "_din_ready_off"}, 32'(din_ready), 0);
        end
        check_rf(tag);
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) exp_rf[i] = (i == 0) ? '0 : 32'h1000_0000 + i;
        rst = 1'b1;
        preset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        preset = 1'b0;
        check_idle_outputs("reset");
        rst = 1'b0;
        check_rf("preset");

        run_dump("dump_full", 0, 1'b0);
        run_dump("dump_toggle", 1, 1'b0);
        run_load("load_full", 0);
        run_dump("dump_after_load", 2, 1'b0);
        run_dump("dump_both_start", 0, 1'b1);
        for (int i = 1; i < NREGS; i++) exp_rf[i] = 32'h1000_0000 + i;
        preset = 1'b1;
        @(posedge clk); #1;
        preset = 1'b0;
        run_load("load_abort", 10);
        run_dump("dump_after_abort", 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
